fft_sample_loader: RTL and testbench
====================================

// Module: fft_sample_loader
// PURPOSE
//  Writer side of the FFT input-sample port: accepts a stream of IEEE-754 single samples and
//  packs them into N-point frames. Storage is a two-bank ping-pong RAM.
//  The FFT engine reads a completed frame through a ROM-style port (address in, data out one
//  cycle later), so the engine's sample source can be swapped from a fixed ROM to live data.
//  The engine holds a bank while processing and releases it with frame_done.
// PARAMETERS
//  ADDR_W   8    log2(frame length N); N = 2**ADDR_W = 256
//  DATA_W   32   sample width (IEEE-754 single)
//  SEQ_W    8    width of frame sequence counter
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        asynchronous reset, active-low
//  s_data       in   DATA_W   input sample
//  s_valid      in   1        s_data valid
//  s_ready      out  1        loader can accept; transfer when s_valid & s_ready
//  rd_addr      in   ADDR_W   FFT read address into the published bank
//  rd_data      out  DATA_W   registered read data, 1-cycle latency
//  frame_ready  out  1        a complete frame is published to the FFT
//  frame_done   in   1        FFT releases published bank (single-cycle pulse)
//  frame_seq    out  SEQ_W    count of frames published since reset, wraps
//  wr_count     out  ADDR_W   samples accepted into current fill bank
// BEHAVIOUR
//  Reset (rst=0, async): state=FILL, wr_bank=0, rd_bank=1, wr_ptr=0, s_ready=0 during reset.
//   rd_data=0, frame_ready=0, frame_seq=0, wr_count=0. RAM contents not reset.
//  States:
//   FILL: s_ready=1. On each transfer, write s_data to bank[wr_bank][waddr(wr_ptr)], wr_ptr++.
//    Transfer with wr_ptr==N-1 ends the frame:
//     if frame_ready==0 or frame_done==1 that cycle, SWAP and stay in FILL;
//     else go to HOLD.
//   HOLD: s_ready=0, no writes. On frame_done: SWAP -> FILL.
//  SWAP (one edge): rd_bank<=wr_bank; wr_bank<=~wr_bank; wr_ptr<=0; frame_ready<=1; frame_seq++.
//  frame_done with no SWAP the same cycle: frame_ready<=0.
//  frame_done while frame_ready==0: ignored.
//  SWAP and frame_done together: SWAP wins, frame_ready stays 1, new frame published.
//  rd_data <= bank[rd_bank][rd_addr] every cycle, independent of frame_ready.
//   rd_data reads the bank selected by rd_bank before any same-edge SWAP.
//  Fill bank is never the published bank, so no read/write collision is possible.
//  wr_count mirrors wr_ptr; it is 0 after SWAP and holds N-1 in HOLD.
//   The frame is complete in HOLD; wr_ptr saturates and does not wrap.
//  Throughput: one sample per cycle in FILL. Latency from last-sample accept to frame_ready=1
//   is 1 cycle when the other bank is free.
//  Reset mid-frame discards the partial frame and the published frame; the FFT must restart.
// CONFIGURATION
//  FFT_LOADER_BITREV_EN defined: waddr = bit-reverse(wr_ptr) over ADDR_W bits.
//   The FFT reads bit-reversed input by natural rd_addr
//   (e.g. N=256: sample 1 -> addr 128, sample 3 -> addr 192).
//  Not defined: waddr = wr_ptr (natural order). Handshake and timing identical in both builds.
// TESTING
//  1 Reset: hold rst=0 with s_valid=1 -> s_ready=0, frame_ready=0, rd_data=0, frame_seq=0.
//  2 Fill: stream 256 samples 0..255 (as float) back-to-back.
//    -> frame_ready=1 one cycle after last accept, frame_seq=1.
//    -> rd_addr=5 returns 5.0 next cycle (natural), or rd_addr=160 returns 5.0 (BITREV_EN).
//  3 Backpressure: fill a 2nd frame without frame_done.
//    -> s_ready=0 after 256th accept, wr_count=255.
//    -> frame_done pulse: SWAP, s_ready=1, frame_seq=2, rd_addr=0 returns 2nd frame's sample 0.
//  4 Collision: assert frame_done on the same cycle as the last sample of frame 2.
//    -> no HOLD, frame_ready stays 1, frame_seq increments, s_ready stays 1.
//  5 Stray/gaps: frame_done while frame_ready=0 -> no state change.
//    -> random s_valid gaps: all 256 samples land at correct addresses.
//  6 Mid-fill reset: after 100 samples pulse rst=0 -> wr_count=0, frame_ready=0, wr_bank=0.
//    -> next 256 samples form frame_seq=1.

Source files
------------

// File: rtl/fft_sample_loader_if.sv
// Bus bundle between the FFT sample loader and its neighbours: the sample stream,
// the engine's ROM-style read port and the frame publish/release handshake.
`timescale 1ns/1ps
interface fft_sample_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_ready;
  logic              frame_done;
  logic [SEQ_W-1:0]  frame_seq;
  logic [ADDR_W-1:0] wr_count;

  modport master (
    output s_data, s_valid, rd_addr, frame_done,
    input  s_ready, rd_data, frame_ready, frame_seq, wr_count
  );

  modport slave (
    input  s_data, s_valid, rd_addr, frame_done,
    output s_ready, rd_data, frame_ready, frame_seq, wr_count
  );
endinterface

// File: rtl/fft_sample_loader.sv
// Packs a sample stream into N-point frames in a two-bank ping-pong RAM for the FFT.
// Optional build macro FFT_LOADER_BITREV_EN stores samples at bit-reversed addresses.
//
// state | meaning
// FILL  | accepting samples into the fill bank
// HOLD  | fill bank complete, waiting for the engine to release the published bank
`timescale 1ns/1ps
module fft_sample_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 8
) (
  input logic               clk,
  input logic               rst,
  fft_sample_loader_if.slave bus
);
  localparam int N = 1 << ADDR_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic              wr_bank, rd_bank;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, waddr;
  logic              frame_ready_q, frame_ready_nxt;
  logic              s_ready_q, s_ready_nxt;
  logic [SEQ_W-1:0]  frame_seq_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              xfer, last, swap;

  logic [DATA_W-1:0] mem [2*N];

  always_comb begin
    xfer            = bus.s_valid && s_ready_q && (state == FILL);
    last            = xfer && (wr_ptr == '1);
    swap            = 1'b0;
    state_nxt       = state;
    wr_ptr_nxt      = wr_ptr;
    frame_ready_nxt = frame_ready_q;
    case (state)
      FILL: begin
        if (xfer && !last) wr_ptr_nxt = wr_ptr + ADDR_W'(1);
        if (last) begin
          if (!frame_ready_q || bus.frame_done) swap = 1'b1;
          else                                  state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.frame_done) begin
          swap      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    // A release coinciding with a publish is absorbed by the new frame.
    if (swap) begin
      wr_ptr_nxt      = '0;
      frame_ready_nxt = 1'b1;
    end else if (bus.frame_done) begin
      frame_ready_nxt = 1'b0;
    end
    s_ready_nxt = (state_nxt == FILL);
  end

  always_comb begin
    waddr = '0;
`ifdef FFT_LOADER_BITREV_EN
    for (int i = 0; i < ADDR_W; i++) waddr[i] = wr_ptr[ADDR_W-1-i];
`else
    waddr = wr_ptr;
`endif
  end

  always_ff @(posedge clk) begin
    if (xfer) mem[{wr_bank, waddr}] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= FILL;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b1;
      wr_ptr        <= '0;
      frame_ready_q <= 1'b0;
      frame_seq_q   <= '0;
      s_ready_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state         <= state_nxt;
      wr_ptr        <= wr_ptr_nxt;
      frame_ready_q <= frame_ready_nxt;
      s_ready_q     <= s_ready_nxt;
      rd_data_q     <= mem[{rd_bank, bus.rd_addr}];
      if (swap) begin
        rd_bank     <= wr_bank;
        wr_bank     <= ~wr_bank;
        frame_seq_q <= frame_seq_q + SEQ_W'(1);
      end
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_seq   = frame_seq_q;
  assign bus.wr_count    = wr_ptr;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: read-port vector table, read scoreboard
// queue and hand-written sequences for backpressure, collision, stray release and reset.
`timescale 1ns/1ps
module tb_fft_sample_loader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int SEQ_W  = 8;
  localparam int N      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_sample_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) bus ();

  fft_sample_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] val;
    logic [ADDR_W-1:0] addr;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                sample;
  } rvec_t;
  rvec_t rtab[6];

  function automatic logic [31:0] fbits(input int unsigned v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 23;
    while (v[e] == 1'b0) e--;
    m = v << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [31:0] sval(input int f, input int i);
    return fbits(int'(f * N + i));
  endfunction

  function automatic logic [ADDR_W-1:0] rev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction

  function automatic int sample_at(input logic [ADDR_W-1:0] a);
`ifdef FFT_LOADER_BITREV_EN
    return int'(rev(a));
`else
    return int'(a);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input logic [ADDR_W-1:0] a, input int f);
    sb_t e;
    e.val  = sval(f, sample_at(a));
    e.addr = a;
    bus.rd_addr = a;
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    chk($sformatf("rd_data@%0d", e.addr), bus.rd_data, e.val);
  endtask

  task automatic run_table(input int f);
    for (int i = 0; i < 6; i++) rd_check(rtab[i].addr, f);
  endtask

  task automatic send(input int f, input int start, input int n, input bit gaps, input bit done_last);
    int idx;
    int cyc;
    bit acc;
    idx = start;
    cyc = 0;
    while (idx < start + n && cyc < n * 8 + 50) begin
      bus.s_valid    = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.s_data     = sval(f, idx);
      bus.frame_done = done_last && (idx == start + n - 1) && bus.s_valid && bus.s_ready;
      acc = bus.s_valid && bus.s_ready;
      tick();
      cyc++;
      if (acc) idx++;
    end
    bus.s_valid    = 1'b0;
    bus.frame_done = 1'b0;
    chk("send_complete", 32'(idx), 32'(start + n));
  endtask

  task automatic pulse_done();
    bus.frame_done = 1'b1;
    tick();
    bus.frame_done = 1'b0;
  endtask

  initial begin
`ifdef FFT_LOADER_BITREV_EN
    rtab[0] = '{addr: 8'd160, sample: 5};
    rtab[1] = '{addr: 8'd0,   sample: 0};
    rtab[2] = '{addr: 8'd255, sample: 255};
    rtab[3] = '{addr: 8'd128, sample: 1};
    rtab[4] = '{addr: 8'd192, sample: 3};
    rtab[5] = '{addr: 8'd1,   sample: 128};
`else
    rtab[0] = '{addr: 8'd5,   sample: 5};
    rtab[1] = '{addr: 8'd0,   sample: 0};
    rtab[2] = '{addr: 8'd255, sample: 255};
    rtab[3] = '{addr: 8'd128, sample: 128};
    rtab[4] = '{addr: 8'd3,   sample: 3};
    rtab[5] = '{addr: 8'd1,   sample: 1};
`endif
    for (int i = 0; i < 6; i++)
      if (sample_at(rtab[i].addr) != rtab[i].sample)
        $display("note: vector table entry %0d inconsistent", i);

    // Reset with the source already offering data
    bus.s_valid    = 1'b1;
    bus.s_data     = fbits(7);
    bus.rd_addr    = '0;
    bus.frame_done = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_s_ready",     32'(bus.s_ready),     32'd0);
    chk("reset_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("reset_rd_data",     bus.rd_data,          32'd0);
    chk("reset_frame_seq",   32'(bus.frame_seq),   32'd0);
    chk("reset_wr_count",    32'(bus.wr_count),    32'd0);
    bus.s_valid = 1'b0;
    rst = 1'b1;
    tick();

    // First frame, with the last sample sent separately to pin the publish latency
    send(0, 0, N - 1, 1'b0, 1'b0);
    chk("f0_pre_last_ready", 32'(bus.frame_ready), 32'd0);
    chk("f0_pre_last_count", 32'(bus.wr_count),    32'd255);
    send(0, N - 1, 1, 1'b0, 1'b0);
    chk("f0_frame_ready", 32'(bus.frame_ready), 32'd1);
    chk("f0_frame_seq",   32'(bus.frame_seq),   32'd1);
    chk("f0_wr_count",    32'(bus.wr_count),    32'd0);
    chk("f0_s_ready",     32'(bus.s_ready),     32'd1);
    run_table(0);

    // Second frame with no release: loader must stall in HOLD
    send(1, 0, N, 1'b0, 1'b0);
    chk("hold_s_ready",     32'(bus.s_ready),     32'd0);
    chk("hold_wr_count",    32'(bus.wr_count),    32'd255);
    chk("hold_frame_ready", 32'(bus.frame_ready), 32'd1);
    chk("hold_frame_seq",   32'(bus.frame_seq),   32'd1);
    rd_check(rtab[0].addr, 0);
    tick();
    chk("hold_s_ready_2", 32'(bus.s_ready), 32'd0);
    pulse_done();
    chk("rel_s_ready",     32'(bus.s_ready),     32'd1);
    chk("rel_frame_seq",   32'(bus.frame_seq),   32'd2);
    chk("rel_wr_count",    32'(bus.wr_count),    32'd0);
    chk("rel_frame_ready", 32'(bus.frame_ready), 32'd1);
    rd_check(8'd0, 1);
    run_table(1);

    // Release on the same cycle as the last sample of the next frame
    send(2, 0, N, 1'b0, 1'b1);
    chk("col_frame_ready", 32'(bus.frame_ready), 32'd1);
    chk("col_frame_seq",   32'(bus.frame_seq),   32'd3);
    chk("col_s_ready",     32'(bus.s_ready),     32'd1);
    chk("col_wr_count",    32'(bus.wr_count),    32'd0);
    run_table(2);

    // Plain release, then a stray release with nothing published
    pulse_done();
    chk("drop_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("drop_frame_seq",   32'(bus.frame_seq),   32'd3);
    pulse_done();
    chk("stray_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("stray_frame_seq",   32'(bus.frame_seq),   32'd3);
    chk("stray_wr_count",    32'(bus.wr_count),    32'd0);
    chk("stray_s_ready",     32'(bus.s_ready),     32'd1);
    run_table(2);

    // Gappy source: every address must hold the right sample
    send(3, 0, N, 1'b1, 1'b0);
    chk("gap_frame_ready", 32'(bus.frame_ready), 32'd1);
    chk("gap_frame_seq",   32'(bus.frame_seq),   32'd4);
    for (int a = 0; a < N; a++) rd_check(ADDR_W'(a), 3);

    // Reset partway through a frame
    send(4, 0, 100, 1'b1, 1'b0);
    chk("mid_wr_count", 32'(bus.wr_count), 32'd100);
    rst = 1'b0;
    #1;
    chk("mrst_wr_count",    32'(bus.wr_count),    32'd0);
    chk("mrst_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("mrst_frame_seq",   32'(bus.frame_seq),   32'd0);
    chk("mrst_s_ready",     32'(bus.s_ready),     32'd0);
    tick();
    rst = 1'b1;
    tick();
    send(5, 0, N, 1'b0, 1'b0);
    chk("post_rst_frame_seq",   32'(bus.frame_seq),   32'd1);
    chk("post_rst_frame_ready", 32'(bus.frame_ready), 32'd1);
    run_table(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
